// File: rtl/data_memory_ctrl.sv
// Data-memory controller: byte/halfword/word loads and stores over a word array.
// A store commits on its accept edge; a load reads the array in ACCESS and responds in RESP.
module data_memory_ctrl #(
    parameter int ADDR_W     = 12,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sign_ext_q, sign_ext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic              illegal;
    logic              accept;
    logic              mem_we;
    logic [3:0]        wr_be;
    logic [31:0]       wr_word;
    logic [31:0]       rd_word_q;
    logic [7:0]        rd_byte_sel;
    logic [15:0]       rd_half_sel;
    logic [31:0]       load_val;

    logic [31:0]       mem [DEPTH];

    // Big-endian builds mirror the lane index; 3-a equals ~a on two bits.
    function automatic logic [1:0] byte_lane(input logic [1:0] a);
        return BIG_ENDIAN ? ~a : a;
    endfunction

    function automatic logic half_lane(input logic a1);
        return a1 ^ BIG_ENDIAN;
    endfunction

    always_comb begin
        case (size)
            SZ_BYTE: illegal = 1'b0;
            SZ_HALF: illegal = addr[0];
            SZ_WORD: illegal = (addr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    assign accept = (state_q == IDLE) && req;
    assign mem_we = accept && we && !illegal;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        wr_be   = 4'b0000;
        wr_word = wdata;
        case (size)
            SZ_BYTE: begin
                wr_be   = 4'b0001 << byte_lane(addr[1:0]);
                wr_word = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                wr_be   = half_lane(addr[1]) ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata[15:0]}};
            end
            SZ_WORD: wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    // NOTE: the array has no reset; contents survive RST and map onto plain RAM.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[addr[ADDR_W-1:2]][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
        if (state_q == ACCESS) begin
            rd_word_q <= mem[addr_q[ADDR_W-1:2]];
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        sign_ext_d = sign_ext_q;
        addr_d     = addr_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d       = we;
                    size_d     = size;
                    sign_ext_d = sign_ext;
                    addr_d     = addr;
                    err_d      = illegal;
                    state_d    = (illegal || we) ? RESP : ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            sign_ext_q <= 1'b0;
            addr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            sign_ext_q <= sign_ext_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
        end
    end

    assign rd_byte_sel = 8'(rd_word_q >> {byte_lane(addr_q[1:0]), 3'b000});
    assign rd_half_sel = 16'(rd_word_q >> {half_lane(addr_q[1]), 4'b0000});

    always_comb begin
        case (size_q)
            SZ_BYTE: load_val = {{24{sign_ext_q & rd_byte_sel[7]}}, rd_byte_sel};
            SZ_HALF: load_val = {{16{sign_ext_q & rd_half_sel[15]}}, rd_half_sel};
            SZ_WORD: load_val = rd_word_q;
            default: load_val = 32'h0;
        endcase
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == RESP);
    assign err   = done && err_q;
    assign rdata = (done && !we_q && !err_q) ? load_val : 32'h0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench: little- and big-endian instances share stimulus and are checked
// against a byte-addressed memory model (each build lays bytes out in its own order).
module tb_data_memory_ctrl;

    localparam int ADDR_W = 12;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              sign_ext = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = '0;

    logic              ready_le, done_le, err_le;
    logic [31:0]       rdata_le;
    logic              ready_be, done_be, err_be;
    logic [31:0]       rdata_be;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mem_le [4096];
    logic [7:0] mem_be [4096];

    always #5 CLK = ~CLK;

    data_memory_ctrl #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b0)) dut_le (
        .CLK(CLK), .RST(RST), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .ready(ready_le), .done(done_le), .err(err_le),
        .rdata(rdata_le)
    );

    data_memory_ctrl #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) dut_be (
        .CLK(CLK), .RST(RST), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .ready(ready_be), .done(done_be), .err(err_be),
        .rdata(rdata_be)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [1:0] sz, input logic [11:0] a);
        return (sz == 2'd0) || (sz == 2'd1 && !a[0]) || (sz == 2'd2 && a[1:0] == 2'b00);
    endfunction

    // Little-endian: lowest address holds the least significant byte; big-endian: the most.
    task automatic model_store(input logic [1:0] sz, input int a, input logic [31:0] wd);
        int n = 1 << sz;
        for (int i = 0; i < n; i++) begin
            mem_le[a+i] = wd[8*i +: 8];
            mem_be[a+i] = wd[8*(n-1-i) +: 8];
        end
    endtask

    function automatic logic [31:0] model_load(input bit be, input logic [1:0] sz,
                                               input logic sx, input int a);
        logic [31:0] v = 32'h0;
        int n = 1 << sz;
        for (int i = 0; i < n; i++) begin
            if (be) v = (v << 8) | 32'(mem_be[a+i]);
            else    v = v | (32'(mem_le[a+i]) << (8*i));
        end
        if (n < 4 && sx && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    // One complete transaction from an IDLE negedge to the next IDLE negedge.
    task automatic op(input logic w, input logic [1:0] sz, input logic sx,
                      input logic [11:0] a, input logic [31:0] wd,
                      output logic [31:0] got_le, output logic [31:0] got_be);
        bit          legal = is_legal(sz, a);
        int          exp_lat = (!legal || w) ? 1 : 2;
        int          lat = 0;
        logic [31:0] exp_le, exp_be;
        for (int i = 0; i < 8 && !ready_le; i++) @(negedge CLK);
        check("ready_before_req", ready_le, 1'b1);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge CLK);
        #1 req = 1'b0;
        if (legal && w) model_store(sz, int'(a), wd);
        exp_le = (legal && !w) ? model_load(1'b0, sz, sx, int'(a)) : 32'h0;
        exp_be = (legal && !w) ? model_load(1'b1, sz, sx, int'(a)) : 32'h0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK);
            if (done_le) begin
                lat = i;
                break;
            end
            check("rdata_zero_before_done", rdata_le, 32'h0);
        end
        check("done_latency", lat, exp_lat);
        check("done_be", done_be, 1'b1);
        check("err_le", err_le, !legal);
        check("err_be", err_be, !legal);
        check("rdata_le", rdata_le, exp_le);
        check("rdata_be", rdata_be, exp_be);
        got_le = rdata_le;
        got_be = rdata_be;
        @(negedge CLK);
        check("done_one_cycle", done_le, 1'b0);
        check("ready_after_resp_le", ready_le, 1'b1);
        check("ready_after_resp_be", ready_be, 1'b1);
    endtask

    initial begin
        logic [31:0] rl, rb, before0, before10;
        logic [31:0] q_le[$];
        logic [31:0] q_be[$];
        logic [11:0] ha;
        logic [31:0] hd;
        int          n_acc, n_done;
        bit          next_store;

        repeat (3) @(negedge CLK);
        check("rst_done", done_le, 1'b0);
        check("rst_err", err_le, 1'b0);
        check("rst_rdata", rdata_le, 32'h0);
        check("rst_done_be", done_be, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_ready_le", ready_le, 1'b1);
        check("rst_ready_be", ready_be, 1'b1);

        // Initialise byte addresses 0x000..0x0FF so every later load has defined data.
        for (int w = 0; w < 64; w++) op(1'b1, 2'd2, 1'b0, 12'(w*4), $urandom, rl, rb);

        // Word store then word load.
        op(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEAD_BEEF, rl, rb);
        op(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, rl, rb);
        check("word_rt_le", rl, 32'hDEAD_BEEF);
        check("word_rt_be", rb, 32'hDEAD_BEEF);

        // Byte store into a cleared word, then signed/unsigned byte loads.
        op(1'b1, 2'd2, 1'b0, 12'h010, 32'h0, rl, rb);
        op(1'b1, 2'd0, 1'b0, 12'h013, 32'h0000_0080, rl, rb);
        op(1'b0, 2'd0, 1'b1, 12'h013, 32'h0, rl, rb);
        check("byte_sext_le", rl, 32'hFFFF_FF80);
        check("byte_sext_be", rb, 32'hFFFF_FF80);
        op(1'b0, 2'd0, 1'b0, 12'h013, 32'h0, rl, rb);
        check("byte_zext_le", rl, 32'h0000_0080);
        op(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, rl, rb);
        check("byte_word_le", rl, 32'h8000_0000);
        check("byte_word_be", rb, 32'h0000_0080);

        // Halfword store into upper/lower lane depending on endianness.
        op(1'b1, 2'd2, 1'b0, 12'h020, 32'hAAAA_AAAA, rl, rb);
        op(1'b1, 2'd1, 1'b0, 12'h022, 32'h0000_1234, rl, rb);
        op(1'b0, 2'd2, 1'b0, 12'h020, 32'h0, rl, rb);
        check("half_word_le", rl, 32'h1234_AAAA);
        check("half_word_be", rb, 32'hAAAA_1234);

        // Illegal accesses: err with rdata 0 and no memory side effects.
        op(1'b0, 2'd2, 1'b0, 12'h000, 32'h0, before0, rb);
        op(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, before10, rb);
        op(1'b0, 2'd2, 1'b0, 12'h005, 32'h0, rl, rb);
        op(1'b1, 2'd1, 1'b0, 12'h001, 32'h0000_FFFF, rl, rb);
        op(1'b0, 2'd3, 1'b0, 12'h010, 32'h0, rl, rb);
        op(1'b1, 2'd3, 1'b0, 12'h010, 32'h5555_5555, rl, rb);
        op(1'b0, 2'd2, 1'b0, 12'h000, 32'h0, rl, rb);
        check("illegal_keeps_0x000", rl, before0);
        op(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, rl, rb);
        check("illegal_keeps_0x010", rl, before10);

        // Randomised mix of sizes, alignments and directions.
        for (int k = 0; k < 300; k++) begin
            op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               12'($urandom_range(0, 255)), $urandom, rl, rb);
        end

        // req held high: alternating word store/load, accepted only while ready.
        n_acc = 0;
        n_done = 0;
        next_store = 1'b1;
        ha = 12'h0;
        req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (done_le) begin
                n_done++;
                if (q_le.size() > 0) begin
                    check("held_rdata_le", rdata_le, q_le.pop_front());
                    check("held_rdata_be", rdata_be, q_be.pop_front());
                end
            end
            if (ready_le) begin
                n_acc++;
                size = 2'd2;
                if (next_store) begin
                    ha = 12'($urandom_range(0, 63) * 4);
                    hd = $urandom;
                    we = 1'b1; addr = ha; wdata = hd;
                    model_store(2'd2, int'(ha), hd);
                    q_le.push_back(32'h0);
                    q_be.push_back(32'h0);
                end else begin
                    we = 1'b0; addr = ha; sign_ext = 1'($urandom_range(0, 1));
                    q_le.push_back(model_load(1'b0, 2'd2, 1'b0, int'(ha)));
                    q_be.push_back(model_load(1'b1, 2'd2, 1'b0, int'(ha)));
                end
                next_store = !next_store;
            end
            @(negedge CLK);
        end
        req = 1'b0;
        for (int d = 0; d < 5; d++) begin
            if (done_le) begin
                n_done++;
                if (q_le.size() > 0) begin
                    check("held_rdata_le", rdata_le, q_le.pop_front());
                    check("held_rdata_be", rdata_be, q_be.pop_front());
                end
            end
            @(negedge CLK);
        end
        check("held_accepts", n_acc, 16);
        check("held_done_count", n_done, n_acc);
        check("held_queue_drained", q_le.size(), 0);

        // Reset during ACCESS of a load: no done afterwards, memory intact.
        op(1'b1, 2'd2, 1'b0, 12'h030, 32'h1234_5678, rl, rb);
        req = 1'b1; we = 1'b0; size = 2'd2; addr = 12'h030;
        @(posedge CLK);
        #1 req = 1'b0;
        @(negedge CLK);
        check("access_not_ready", ready_le, 1'b0);
        RST = 1'b0;
        #1;
        check("rst_access_done", done_le, 1'b0);
        check("rst_access_rdata", rdata_le, 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        for (int d = 0; d < 4; d++) begin
            @(negedge CLK);
            check("no_done_after_abort_le", done_le, 1'b0);
            check("no_done_after_abort_be", done_be, 1'b0);
        end
        check("ready_after_abort", ready_le, 1'b1);
        op(1'b0, 2'd2, 1'b0, 12'h030, 32'h0, rl, rb);
        check("mem_kept_after_abort", rl, 32'h1234_5678);

        // Reset right after a store's accept edge: store kept, done suppressed.
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 12'h034; wdata = 32'hCAFE_F00D;
        @(posedge CLK);
        #1 req = 1'b0;
        model_store(2'd2, 32'h34, 32'hCAFE_F00D);
        RST = 1'b0;
        #1;
        check("rst_resp_done", done_le, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        for (int d = 0; d < 3; d++) begin
            @(negedge CLK);
            check("no_done_after_store_rst", done_le, 1'b0);
        end
        op(1'b0, 2'd2, 1'b0, 12'h034, 32'h0, rl, rb);
        check("store_kept_le", rl, 32'hCAFE_F00D);
        check("store_kept_be", rb, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
